// File: rtl/dp_control_sequencer.sv
// Strobe sequencer for the RA/RB/RZ datapath: IDLE -> T0 [-> T1]* -> DONE, Moore outputs.
// start is taken only in IDLE; LDA/MOVAB finish in 2 cycles, ADDB in 3, ACC N in 1+2N.
module dp_control_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [CNT_W-1:0] count,
  output logic             RAin,
  output logic             RBin,
  output logic             RZin,
  output logic             RAout,
  output logic             RBout,
  output logic             RZout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T0   = 2'b01,
    S_T1   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0]       OP_LDA   = 2'b00;
  localparam logic [1:0]       OP_MOVAB = 2'b01;
  localparam logic [1:0]       OP_ADDB  = 2'b10;
  localparam logic [1:0]       OP_ACC   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = opcode;
          cnt_d = count;
          state_d = (opcode == OP_ACC && count == '0) ? S_DONE : S_T0;
        end
      end
      S_T0: begin
        state_d = (op_q == OP_LDA || op_q == OP_MOVAB) ? S_DONE : S_T1;
      end
      S_T1: begin
        if (op_q == OP_ACC) begin
          // Test before decrementing so a count of all-ones runs in full without wrapping.
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? S_DONE : S_T0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    RAin  = 1'b0;
    RBin  = 1'b0;
    RZin  = 1'b0;
    RAout = 1'b0;
    RBout = 1'b0;
    RZout = 1'b0;
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    case (state_q)
      S_T0: begin
        case (op_q)
          OP_LDA:   RAin = 1'b1;
          OP_MOVAB: begin
            RAout = 1'b1;
            RBin  = 1'b1;
          end
          default: begin
            RBout = 1'b1;
            RZin  = 1'b1;
          end
        endcase
      end
      S_T1: begin
        RZout = 1'b1;
        RBin  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_control_sequencer.sv
// Directed bench for dp_control_sequencer with an attached 8-bit RA/RB/RZ datapath.
module tb_dp_control_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic [3:0] count = 4'd0;
  logic       RAin, RBin, RZin, RAout, RBout, RZout, busy, done;

  logic [7:0] imm = 8'd0;
  logic [7:0] ra = 8'd0, rb = 8'd0, rz = 8'd0;
  logic [7:0] bus;

  int tests = 0;
  int fails = 0;
  int lat, n_rain, n_movab, n_t0, n_t1, n_busy, n_other;
  logic inv_en = 1'b0;

  dp_control_sequencer #(.CNT_W(4)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .opcode(opcode),
    .count (count),
    .RAin  (RAin),
    .RBin  (RBin),
    .RZin  (RZin),
    .RAout (RAout),
    .RBout (RBout),
    .RZout (RZout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  always_comb begin
    bus = 8'd0;
    if (RAout)      bus = ra;
    else if (RBout) bus = rb;
    else if (RZout) bus = rz;
  end

  always @(posedge clock) begin
    if (RAin) ra <= imm;
    if (RBin) rb <= bus;
    if (RZin) rz <= ra + bus;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (inv_en && !clear) begin
      chk("inv_out_onehot", 32'($countones({RAout, RBout, RZout}) <= 1), 32'd1);
      chk("inv_in_onehot",  32'($countones({RAin, RBin, RZin}) <= 1), 32'd1);
      chk("inv_self_load",  32'((RBin & RBout) | (RAin & RAout)), 32'd0);
      chk("inv_done_busy",  32'(done & ~busy), 32'd0);
    end
  end

  // Issues one op at a negedge; tallies strobe cycles until done. With poke, start is
  // held high (with a different opcode) through the busy and DONE cycles.
  task automatic run_op(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] imm_v,
                        input int exp_lat, input bit poke, input string tag);
    @(negedge clock);
    opcode = op; count = cnt; imm = imm_v; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = poke;
    if (poke) begin
      opcode = 2'b00;
      count  = 4'd9;
    end
    lat = 1; n_rain = 0; n_movab = 0; n_t0 = 0; n_t1 = 0; n_busy = 0; n_other = 0;
    forever begin
      if (busy) n_busy++;
      if (RAin) n_rain++;
      else if (RAout && RBin) n_movab++;
      else if (RBout && RZin) n_t0++;
      else if (RZout && RBin) n_t1++;
      else if (RBin || RZin || RAout || RBout || RZout) n_other++;
      if (done || lat >= 60) break;
      @(negedge clock);
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_lat));
    chk({tag, "_stray_strobes"}, 32'(n_other), 32'd0);
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
    @(negedge clock);
    chk({tag, "_no_extra_op"}, 32'({busy, RAin, RBin, RZin}), 32'd0);
  endtask

  initial begin
    // Reset held two cycles with start asserted
    clear = 1'b1; start = 1'b1; opcode = 2'b11; count = 4'd3;
    @(posedge clock); @(negedge clock);
    chk("rst1_outputs", 32'({RAin, RBin, RZin, RAout, RBout, RZout, busy, done}), 32'd0);
    @(posedge clock); @(negedge clock);
    chk("rst2_outputs", 32'({RAin, RBin, RZin, RAout, RBout, RZout, busy, done}), 32'd0);
    clear = 1'b0; start = 1'b0;
    inv_en = 1'b1;
    @(negedge clock);
    chk("idle_after_rst", 32'({busy, done}), 32'd0);

    // LDA 5, MOVAB -> RA=5, RB=5
    run_op(2'b00, 4'd0, 8'd5, 2, 1'b0, "lda5");
    chk("lda5_rain_cycles", 32'(n_rain), 32'd1);
    chk("lda5_ra", 32'(ra), 32'd5);
    run_op(2'b01, 4'd0, 8'd0, 2, 1'b0, "movab");
    chk("movab_cycles", 32'(n_movab), 32'd1);
    chk("movab_rb", 32'(rb), 32'd5);

    // LDA 3, ADDB -> RZ=8, RB=8; start poked throughout busy/DONE
    run_op(2'b00, 4'd0, 8'd3, 2, 1'b0, "lda3");
    chk("lda3_ra", 32'(ra), 32'd3);
    run_op(2'b10, 4'd0, 8'd0, 3, 1'b1, "addb");
    chk("addb_t0", 32'(n_t0), 32'd1);
    chk("addb_t1", 32'(n_t1), 32'd1);
    chk("addb_rz", 32'(rz), 32'd8);
    chk("addb_rb", 32'(rb), 32'd8);
    chk("addb_ra_kept", 32'(ra), 32'd3);

    // ACC 3 with A=3, RB=8 -> RB=17
    run_op(2'b11, 4'd3, 8'd0, 7, 1'b0, "acc3");
    chk("acc3_t0", 32'(n_t0), 32'd3);
    chk("acc3_t1", 32'(n_t1), 32'd3);
    chk("acc3_rb", 32'(rb), 32'd17);

    // ACC 0 -> straight to DONE, no strobes
    run_op(2'b11, 4'd0, 8'd0, 1, 1'b1, "acc0");
    chk("acc0_strobes", 32'(n_t0 + n_t1 + n_rain + n_movab), 32'd0);
    chk("acc0_rb", 32'(rb), 32'd17);

    // Overflow: A=200, RB=100 -> ADDB gives 44
    run_op(2'b00, 4'd0, 8'd100, 2, 1'b0, "lda100");
    run_op(2'b01, 4'd0, 8'd0, 2, 1'b0, "mov100");
    chk("mov100_rb", 32'(rb), 32'd100);
    run_op(2'b00, 4'd0, 8'd200, 2, 1'b0, "lda200");
    run_op(2'b10, 4'd0, 8'd0, 3, 1'b0, "addb_ovf");
    chk("addb_ovf_rb", 32'(rb), 32'd44);

    // ACC 15: 44 + 15*200 = 3044 mod 256 = 228
    run_op(2'b11, 4'd15, 8'd0, 31, 1'b1, "acc15");
    chk("acc15_t0", 32'(n_t0), 32'd15);
    chk("acc15_t1", 32'(n_t1), 32'd15);
    chk("acc15_rb", 32'(rb), 32'd228);

    // Clear during ACC T1 aborts without a done pulse
    @(negedge clock);
    opcode = 2'b11; count = 4'd3; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!RZout && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    chk("abort_reached_t1", 32'(RZout), 32'd1);
    clear = 1'b1;
    @(negedge clock);
    chk("abort_outputs", 32'({busy, done, RBin, RZout}), 32'd0);
    clear = 1'b0;
    @(negedge clock);
    chk("abort_stays_idle", 32'({busy, done}), 32'd0);

    // Random opcode/count stream; invariants are checked every cycle
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      start  = ($urandom_range(0, 3) == 0);
      opcode = 2'($urandom_range(0, 3));
      count  = 4'($urandom_range(0, 15));
      imm    = 8'($urandom_range(0, 255));
    end
    start = 1'b0;
    repeat (40) @(negedge clock);
    chk("random_end_idle", 32'(busy), 32'd0);

    inv_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dp_control_sequencer.md
Name: dp_control_sequencer

Overview:
- Control FSM that drives the register/bus datapath: generates register load strobes (RAin, RBin, RZin) and bus-drive selects (RAout, RBout, RZout) from a small opcode set.
- Sits between the instruction source and the datapath. It is the controlling end of the datapath's strobe interface.
- Sequences single-step and repeated add-accumulate operations using a start/done handshake.

Parameters:
- CNT_W, 4, width of the repeat-count input and internal iteration counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset.
- start  input  1  request to execute opcode; sampled only in IDLE.
- opcode  input  2  00 LDA, 01 MOVAB, 10 ADDB, 11 ACC.
- count  input  CNT_W  iteration count for ACC; ignored for other opcodes.
- RAin  output  1  load RA from immediate.
- RBin  output  1  load RB from bus.
- RZin  output  1  load RZ from adder (A + bus).
- RAout  output  1  RA drives bus.
- RBout  output  1  RB drives bus.
- RZout  output  1  RZ drives bus.
- busy  output  1  high from first execute cycle through DONE cycle.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: clear=1 at a rising edge forces state IDLE and zeroes the latched opcode and counter. All six strobes, busy and done are 0. Reset mid-operation aborts immediately, with no completion pulse.
- States: IDLE, T0, T1, DONE. Outputs are Moore, decoded from registered state and latched opcode only.
- IDLE: strobes 0, busy 0. When start=1, latch opcode and count.
  - For ACC with count=0, next state is DONE.
  - Otherwise next state is T0.
- T0 strobes:
  - LDA: RAin.
  - MOVAB: RAout and RBin.
  - ADDB or ACC: RBout and RZin.
  - Next state: LDA and MOVAB go to DONE; ADDB and ACC go to T1.
- T1 strobes: RZout and RBin (RB <= Z).
  - ADDB goes to DONE.
  - ACC decrements the counter. If the counter equals 1 before the decrement, go to DONE; else go to T0.
- DONE: done=1 and busy=1, strobes 0. Next state is IDLE.
- Latency, with start sampled at edge k:
  - LDA and MOVAB: T0 in cycle k+1, done in k+2.
  - ADDB: done in k+3.
  - ACC with N≥1: done in k+1+2N.
  - ACC with N=0: done in k+1.
- start while busy is ignored, not queued. start in the DONE cycle is ignored. Back-to-back operations therefore have a minimum spacing of one IDLE cycle.
- Invariants, checked every cycle:
  - At most one of RAout/RBout/RZout is high (no bus contention).
  - At most one *in strobe is high.
  - No register is loaded from the bus while that same register drives it.
- Counter is CNT_W bits; the maximum count of 2^CNT_W−1 is supported without wrap.
- Datapath arithmetic is mod 256. The sequencer has no knowledge of data.

Test Plan:
- Reset: drive clear=1 for 2 cycles with start=1 -> all strobes, busy and done are 0 and the state is IDLE. Assert clear during ACC T1 -> the next cycle is IDLE, with no done pulse and RBin=0.
- LDA then MOVAB (with the datapath attached, immediate=5) -> RAin for exactly 1 cycle, done at k+2, RA=5. MOVAB then drives RAout+RBin for 1 cycle, giving RB=5.
- ADDB with A=3, RB=5 -> T0 asserts RBout+RZin, giving RZ=8. T1 asserts RZout+RBin, giving RB=8. done pulses at k+3.
- ACC count=3, A=3, RB=8 -> strobe pattern (RBout,RZin),(RZout,RBin) repeats 3 times, RB=17, done at k+7. ACC count=0 -> no strobes, done at k+1.
- Overflow: A=200, RB=100, ADDB -> RB=44. With CNT_W=4, ACC count=15 -> exactly 15 iterations, done at k+31.
- Handshake and invariants: pulse start during busy and during the DONE cycle -> ignored, no extra operation. A randomized opcode/count stream run for 10k cycles -> one-hot bus-drive and load invariants never violated.
